// File: rtl/ibr128_dec_opmode.sv
// ---------------------------------------------------------------------------
// ibr128_dec_opmode
//
// Purpose:
//   Decryption-side mode-of-operation sequencer for the IBR128 datapath.
//   Accepts one ciphertext block per request and applies ECB/CBC/CFB/OFB
//   chaining around the shared IBR128 block-cipher engine. The engine is
//   driven through its block_start/block_ready handshake, and the recovered
//   plaintext is returned with a one-cycle plainReady pulse.
//
// Ports:
//   Clk          system clock, rising edge
//   RstN         asynchronous active-low reset
//   Enable       single-cycle decrypt request, accepted only when idle
//   SOM[1:0]     mode: 00 ECB, 01 CBC, 10 CFB-128, 11 OFB
//   FB           first block: load the chain register from IV
//   IV           initialisation vector
//   cipherText   ciphertext block, sampled with Enable
//   plainText    registered plaintext, held until the next result
//   plainReady   one-cycle pulse when plainText is valid
//   busy         high from START through OUT
//   encrypt      engine direction: 1 forward, 0 inverse
//   block_start  one-cycle engine start pulse
//   pData        engine input block
//   block_ready  engine completion pulse (honoured only while waiting)
//   eData        engine output, valid with block_ready
//   err          engine watchdog-expired pulse
//
// Optional feature (macro IBR128_DEC_TIMEOUT_EN):
//   When defined, a watchdog aborts the wait for block_ready after
//   TIMEOUT_CYCLES cycles and pulses err. When undefined, err is tied to 0
//   and the sequencer waits for the engine indefinitely.
// ---------------------------------------------------------------------------
module ibr128_dec_opmode #(
   parameter int BLK_W          = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Enable,
   input  logic [1:0]       SOM,
   input  logic             FB,
   input  logic [BLK_W-1:0] IV,
   input  logic [BLK_W-1:0] cipherText,
   output logic [BLK_W-1:0] plainText,
   output logic             plainReady,
   output logic             busy,
   output logic             encrypt,
   output logic             block_start,
   output logic [BLK_W-1:0] pData,
   input  logic             block_ready,
   input  logic [BLK_W-1:0] eData,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic [1:0] MODE_ECB = 2'b00;
   localparam logic [1:0] MODE_CBC = 2'b01;
   localparam logic [1:0] MODE_CFB = 2'b10;
   localparam logic [1:0] MODE_OFB = 2'b11;

   state_t           r_state;
   state_t           w_next;
   logic [BLK_W-1:0] r_chain;
   logic [BLK_W-1:0] r_c;
   logic [1:0]       r_mode;
   logic [BLK_W-1:0] r_plain;
   logic             w_accept;
   logic             w_done;
   logic             w_timeout;

   assign w_accept = (r_state == S_IDLE) && Enable;
   assign w_done   = (r_state == S_WAIT) && block_ready;

`ifdef IBR128_DEC_TIMEOUT_EN
   logic [15:0] r_cnt;

   // Watchdog: zeroed in START so the first WAIT cycle sees 0, then counts
   // every WAIT cycle. Expiry is only declared if the engine is not
   // completing in that same cycle.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_cnt <= '0;
      end else if (r_state == S_START) begin
         r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign w_timeout = (r_state == S_WAIT) && !block_ready &&
                      (r_cnt == 16'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. block_ready is only looked at in WAIT, so a completion
   // pulse coincident with block_start (or arriving after a timeout) is
   // ignored.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (Enable) w_next = S_START;
         S_START: w_next = S_WAIT;
         S_WAIT: begin
            if (block_ready) begin
               w_next = S_OUT;
            end else if (w_timeout) begin
               w_next = S_IDLE;
            end
         end
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture and result/chain update. The chain register is only
   // reloaded from IV on a first block, so a mode change between blocks
   // reuses whatever chain value is already held.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         r_chain <= '0;
         r_c     <= '0;
         r_mode  <= MODE_ECB;
         r_plain <= '0;
      end else begin
         if (w_accept) begin
            r_c    <= cipherText;
            r_mode <= SOM;
            if (FB) begin
               r_chain <= IV;
            end
         end
         if (w_done) begin
            case (r_mode)
               MODE_ECB: begin
                  r_plain <= eData;
               end
               MODE_CBC: begin
                  r_plain <= eData ^ r_chain;
                  r_chain <= r_c;
               end
               MODE_CFB: begin
                  r_plain <= eData ^ r_c;
                  r_chain <= r_c;
               end
               default: begin
                  r_plain <= eData ^ r_c;
                  r_chain <= eData;
               end
            endcase
         end
      end
   end

   // ECB/CBC run the engine inverse on the ciphertext; CFB/OFB run it forward
   // on the chain value. Both sources are frozen from START until block_ready.
   assign encrypt     = r_mode[1];
   assign pData       = r_mode[1] ? r_chain : r_c;
   assign block_start = (r_state == S_START);
   assign plainReady  = (r_state == S_OUT);
   assign busy        = (r_state != S_IDLE);
   assign plainText   = r_plain;
   assign err         = w_timeout;

endmodule

// File: tb/tb_ibr128_dec_opmode.sv
// ---------------------------------------------------------------------------
// tb_ibr128_dec_opmode
//
// Directed bench for ibr128_dec_opmode. A stub engine returns pData ^ K
// (K = all bytes A5) three cycles after block_start. Expected plaintexts are
// hand-derived from the chaining equations for each mode.
// ---------------------------------------------------------------------------
module tb_ibr128_dec_opmode;

   localparam int TOUT = 64;
   localparam logic [127:0] K = {16{8'hA5}};

   logic         Clk;
   logic         RstN;
   logic         Enable;
   logic [1:0]   SOM;
   logic         FB;
   logic [127:0] IV;
   logic [127:0] cipherText;
   logic [127:0] plainText;
   logic         plainReady;
   logic         busy;
   logic         encrypt;
   logic         block_start;
   logic [127:0] pData;
   logic         block_ready;
   logic [127:0] eData;
   logic         err;

   int vectors;
   int miscompares;
   int prCount;
   logic engineOn;
   logic [2:0] stubPipe;

   ibr128_dec_opmode #(.BLK_W(128), .TIMEOUT_CYCLES(TOUT)) dut (
      .Clk(Clk), .RstN(RstN), .Enable(Enable), .SOM(SOM), .FB(FB), .IV(IV),
      .cipherText(cipherText), .plainText(plainText), .plainReady(plainReady),
      .busy(busy), .encrypt(encrypt), .block_start(block_start), .pData(pData),
      .block_ready(block_ready), .eData(eData), .err(err)
   );

   // Free-running clock.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Stub engine: completion three cycles after the start pulse.
   always @(posedge Clk or negedge RstN) begin
      if (!RstN) stubPipe <= '0;
      else       stubPipe <= {stubPipe[1:0], block_start};
   end
   assign block_ready = stubPipe[2] & engineOn;
   assign eData       = pData ^ K;

   // Count every plainReady pulse seen by the clock.
   always @(posedge Clk) begin
      if (RstN && plainReady) prCount <= prCount + 1;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to plainReady. When collide is set, a
   // second Enable with different data is driven during WAIT.
   task automatic applyStimulus(input string tag, input logic [1:0] som, input logic fb,
                                input logic [127:0] iv, input logic [127:0] ct,
                                input logic [127:0] expPData, input logic expEnc,
                                input logic [127:0] expPlain, input logic collide);
      int lat;
      int prBefore;
      prBefore = prCount;
      SOM = som; FB = fb; IV = iv; cipherText = ct; Enable = 1'b1;
      tick();
      Enable = 1'b0;
      lat = 1;
      checkOutput({tag, " block_start"}, {127'd0, block_start}, 128'd1);
      checkOutput({tag, " encrypt"}, {127'd0, encrypt}, {127'd0, expEnc});
      checkOutput({tag, " pData"}, pData, expPData);
      while (!plainReady && lat < 40) begin
         if (collide && lat == 2) begin
            Enable = 1'b1; cipherText = ~ct; IV = ~iv; FB = 1'b1; SOM = ~som;
         end else begin
            Enable = 1'b0;
         end
         tick();
         lat++;
      end
      Enable = 1'b0;
      checkOutput({tag, " latency"}, 128'(lat), 128'd5);
      checkOutput({tag, " plainText"}, plainText, expPlain);
      tick();
      checkOutput({tag, " busy after"}, {127'd0, busy}, 128'd0);
      repeat (4) tick();
      checkOutput({tag, " pulse count"}, 128'(prCount - prBefore), 128'd1);
   endtask

   initial begin
      vectors = 0; miscompares = 0; prCount = 0; engineOn = 1'b1;
      RstN = 1'b0; Enable = 1'b1; SOM = 2'b11; FB = 1'b1;
      IV = 128'h1234; cipherText = 128'h5678;

      // Reset held with Enable active: every output is 0.
      repeat (3) tick();
      checkOutput("rst plainText", plainText, 128'd0);
      checkOutput("rst plainReady", {127'd0, plainReady}, 128'd0);
      checkOutput("rst busy", {127'd0, busy}, 128'd0);
      checkOutput("rst encrypt", {127'd0, encrypt}, 128'd0);
      checkOutput("rst block_start", {127'd0, block_start}, 128'd0);
      checkOutput("rst pData", pData, 128'd0);
      checkOutput("rst err", {127'd0, err}, 128'd0);
      Enable = 1'b0;
      RstN = 1'b1;
      tick();

      // Reset asserted in WAIT aborts the block with no plainReady.
      SOM = 2'b00; FB = 1'b0; cipherText = 128'h7; Enable = 1'b1;
      tick();
      Enable = 1'b0;
      tick();
      checkOutput("abort busy in wait", {127'd0, busy}, 128'd1);
      RstN = 1'b0;
      #1;
      checkOutput("abort busy", {127'd0, busy}, 128'd0);
      checkOutput("abort plainReady", {127'd0, plainReady}, 128'd0);
      repeat (6) tick();
      RstN = 1'b1;
      repeat (2) tick();
      checkOutput("abort pulse count", 128'(prCount), 128'd0);

      // ECB single block.
      applyStimulus("ecb", 2'b00, 1'b0, 128'd0, 128'h1, 128'h1, 1'b0, K ^ 128'h1, 1'b0);

      // CBC: P1 = K^10^0F, chain <= 10; P2 = K^20^10.
      applyStimulus("cbc1", 2'b01, 1'b1, 128'h0F, 128'h10, 128'h10, 1'b0, K ^ 128'h1F, 1'b0);
      applyStimulus("cbc2", 2'b01, 1'b0, 128'h0, 128'h20, 128'h20, 1'b0, K ^ 128'h30, 1'b0);

      // OFB: pData1 = 3C, P1 = 3C^K^01, chain <= 3C^K; pData2 = 3C^K, P2 = 3C^02.
      applyStimulus("ofb1", 2'b11, 1'b1, 128'h3C, 128'h01, 128'h3C, 1'b1, K ^ 128'h3D, 1'b0);
      applyStimulus("ofb2", 2'b11, 1'b0, 128'h0, 128'h02, K ^ 128'h3C, 1'b1, 128'h3E, 1'b0);

      // CFB: pData1 = 77, P1 = 77^K^55, chain <= 55; pData2 = 55, P2 = 55^K^66.
      applyStimulus("cfb1", 2'b10, 1'b1, 128'h77, 128'h55, 128'h77, 1'b1, K ^ 128'h22, 1'b0);
      applyStimulus("cfb2", 2'b10, 1'b0, 128'h0, 128'h66, 128'h55, 1'b1, K ^ 128'h33, 1'b0);

      // Mode change without FB: CBC uses the chain left by CFB (66).
      applyStimulus("cbcswitch", 2'b01, 1'b0, 128'h0, 128'h99, 128'h99, 1'b0, K ^ 128'hFF, 1'b0);

      // Busy collision: second Enable in WAIT is ignored.
      applyStimulus("collide", 2'b00, 1'b0, 128'h0, 128'h5, 128'h5, 1'b0, K ^ 128'h5, 1'b1);

`ifdef IBR128_DEC_TIMEOUT_EN
      begin
         int lat;
         int prBefore;
         logic errSeen;
         prBefore = prCount;
         engineOn = 1'b0;
         errSeen = 1'b0;
         SOM = 2'b00; FB = 1'b0; cipherText = 128'h9; Enable = 1'b1;
         tick();
         Enable = 1'b0;
         lat = 1;
         while (lat < 200 && !errSeen) begin
            if (err) errSeen = 1'b1;
            else begin
               tick();
               lat++;
            end
         end
         checkOutput("tout err seen", {127'd0, errSeen}, 128'd1);
         checkOutput("tout latency", 128'(lat), 128'(TOUT + 2));
         tick();
         checkOutput("tout err pulse", {127'd0, err}, 128'd0);
         checkOutput("tout busy", {127'd0, busy}, 128'd0);
         checkOutput("tout plainText", plainText, K ^ 128'h5);
         checkOutput("tout no ready", 128'(prCount - prBefore), 128'd0);
         engineOn = 1'b1;
         tick();
         applyStimulus("tout ecb", 2'b00, 1'b0, 128'h0, 128'h3, 128'h3, 1'b0, K ^ 128'h3, 1'b0);
      end
`else
      checkOutput("err tied low", {127'd0, err}, 128'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ibr128_dec_opmode.md
Name: ibr128_dec_opmode

Overview:
Decryption-side mode-of-operation sequencer for the IBR128 datapath. Accepts one 128-bit ciphertext block per request and applies ECB/CBC/CFB/OFB chaining. Drives the shared IBR128 block-cipher engine through its block_start/block_ready handshake, then returns the recovered plaintext. It is the receive-end counterpart of the encrypt-side opmode controller and sits between the host interface and the cipher engine.

Parameters:
BLK_W, 128, block and IV width; fixed at 128 for IBR128.
TIMEOUT_CYCLES, 64, engine watchdog limit in cycles; used only when IBR128_DEC_TIMEOUT_EN is defined.

Ports:
Clk  in  1  system clock; all logic on rising edge
RstN  in  1  asynchronous active-low reset
Enable  in  1  single-cycle request to decrypt cipherText; accepted only in IDLE
SOM  in  2  mode: 00 ECB, 01 CBC, 10 CFB (128-bit feedback), 11 OFB; sampled with Enable
FB  in  1  first block: load the chain register from IV; sampled with Enable
IV  in  BLK_W  initialisation vector
cipherText  in  BLK_W  ciphertext block; sampled with Enable
plainText  out  BLK_W  recovered plaintext; registered; holds until next result
plainReady  out  1  one-cycle pulse when plainText is valid
busy  out  1  high from the cycle after acceptance until the plainReady cycle, inclusive
encrypt  out  1  engine direction: 1 forward, 0 inverse
block_start  out  1  one-cycle engine start pulse
pData  out  BLK_W  engine input block
block_ready  in  1  engine completion pulse
eData  in  BLK_W  engine output; valid when block_ready=1
err  out  1  watchdog-expired pulse; tied 0 without IBR128_DEC_TIMEOUT_EN

Behaviour:
- Reset (RstN=0, asynchronous): all outputs 0. FSM goes to IDLE. chain_q, c_q and the mode register clear to 0. A reset during any state aborts the operation with no plainReady.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE → START on Enable=1. Capture c_q<=cipherText and mode_q<=SOM. If FB=1, load chain_q<=IV; otherwise chain_q keeps its value.
- START: drive block_start=1 for exactly one cycle, then go to WAIT.
  - ECB/CBC: pData=c_q, encrypt=0.
  - CFB/OFB: pData=chain_q, encrypt=1.
  - pData and encrypt stay stable from START until block_ready.
- WAIT → OUT on block_ready=1. Register plainText:
  - ECB: eData.
  - CBC: eData^chain_q; then chain_q<=c_q.
  - CFB: eData^c_q; then chain_q<=c_q.
  - OFB: eData^c_q; then chain_q<=eData.
- OUT: plainReady=1 for one cycle, then go to IDLE.
- Latency: Enable at cycle 0 → block_start at cycle 1. If block_ready arrives at cycle 1+N, plainReady is at cycle 2+N.
- Enable in any non-IDLE state is ignored and does not change captured inputs.
- block_ready outside WAIT is ignored. block_ready in the same cycle as block_start does not count.
- A mode change between blocks is allowed: chaining uses the new SOM with the existing chain_q unless FB=1.
- busy=0 in IDLE, 1 in START/WAIT/OUT.

Optional Feature:
Macro IBR128_DEC_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without block_ready:
  - pulse err for one cycle and return to IDLE;
  - no plainReady; chain_q and plainText unchanged;
  - a late block_ready is then ignored.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
Bench uses a stub engine with eData=pData^K, K=128'hA5A5…A5 (all bytes A5), block_ready 3 cycles after block_start.
1. Reset: hold RstN=0 with Enable=1 → all outputs 0. Assert RstN=0 during WAIT → plainReady never pulses, busy=0 immediately.
2. ECB: SOM=00, cipherText=128'h1 → encrypt=0 at block_start, plainReady at cycle 5 after Enable, plainText=K^1 (…A5A4).
3. CBC two blocks: IV=128'h0F, C1=128'h10 with FB=1 → P1=K^10^0F. Then C2=128'h20 with FB=0 → P2=K^20^10.
4. OFB two blocks: IV=V=128'h3C, C1=128'h01, C2=128'h02 → encrypt=1, pData1=V, P1=V^K^01. Then pData2=V^K, P2=V^02.
5. Busy collision: Enable again during WAIT with a different cipherText → ignored; only one plainReady; result from the first block.
6. (IBR128_DEC_TIMEOUT_EN) stub never asserts block_ready → err pulses TIMEOUT_CYCLES cycles after WAIT entry, busy falls, no plainReady; the next ECB request completes normally.
